// File: rtl/sprite_plot_arbiter.sv
// Round-robin owner of the single VGA pixel-write port shared by the sprite engines.
// The granted engine streams pixels until its last pixel, until it drops req, or until a burst limit forces release.
module sprite_plot_arbiter #(
  parameter int N_REQ     = 5,
  parameter int XW        = 9,
  parameter int YW        = 8,
  parameter int CW        = 3,
  parameter int MAX_BURST = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    px_valid,
  input  logic [N_REQ-1:0]    px_last,
  input  logic [N_REQ*XW-1:0] px_x,
  input  logic [N_REQ*YW-1:0] px_y,
  input  logic [N_REQ*CW-1:0] px_col,
  output logic [N_REQ-1:0]    gnt,
  output logic [XW-1:0]       x,
  output logic [YW-1:0]       y,
  output logic [CW-1:0]       colour,
  output logic                plot,
  output logic                busy,
  output logic                timeout_err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_rr_ptr;
  logic [IW-1:0]    r_gidx;
  logic [BW-1:0]    r_burst_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic [CW-1:0]    r_col;
  logic             r_plot;
  logic             r_busy;
  logic             r_timeout;

  logic [IW:0]      w_scan;
  logic [IW-1:0]    w_win_idx;
  logic             w_win_found;
  logic             w_hit;
  logic             w_g_req;
  logic             w_g_valid;
  logic             w_g_last;
  logic             w_accept;
  logic [BW-1:0]    w_cnt_next;
  logic             w_hit_max;
  logic             w_release;
  logic [IW-1:0]    w_next_ptr;
  logic [XW-1:0]    w_sel_x;
  logic [YW-1:0]    w_sel_y;
  logic [CW-1:0]    w_sel_col;

  // Round-robin search: walk offsets from farthest to nearest so the nearest set request from r_rr_ptr wins.
  always_comb begin
    w_scan      = '0;
    w_hit       = 1'b0;
    w_win_idx   = '0;
    w_win_found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_scan      = {1'b0, r_rr_ptr} + (IW+1)'(k);
      w_scan      = (w_scan >= (IW+1)'(N_REQ)) ? (w_scan - (IW+1)'(N_REQ)) : w_scan;
      w_hit       = req[w_scan[IW-1:0]];
      w_win_found = w_win_found | w_hit;
      w_win_idx   = w_hit ? w_scan[IW-1:0] : w_win_idx;
    end
  end

  // Views of the granted requester only; other engines never reach the outputs.
  always_comb begin
    w_g_req    = req[r_gidx];
    w_g_valid  = px_valid[r_gidx];
    w_g_last   = px_last[r_gidx];
    w_sel_x    = px_x[r_gidx*XW +: XW];
    w_sel_y    = px_y[r_gidx*YW +: YW];
    w_sel_col  = px_col[r_gidx*CW +: CW];
    w_accept   = (r_state == ST_GRANT) & w_g_req & w_g_valid;
    w_cnt_next = r_burst_cnt + BW'(1);
    // Release priority: last pixel, then abort, then forced release at the burst limit.
    w_hit_max  = w_accept & ~w_g_last & (w_cnt_next == BURST_LIM);
    w_release  = (r_state == ST_GRANT) & ((w_accept & w_g_last) | ~w_g_req | w_hit_max);
    w_next_ptr = (r_gidx == IW'(N_REQ - 1)) ? '0 : (r_gidx + IW'(1));
  end

  // Arbiter FSM with all port-facing state registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_gidx      <= '0;
      r_burst_cnt <= '0;
      r_gnt       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_col       <= '0;
      r_plot      <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_plot    <= 1'b0;
          r_timeout <= 1'b0;
          if (w_win_found) begin
            r_gnt       <= ONE_HOT0 << w_win_idx;
            r_busy      <= 1'b1;
            r_burst_cnt <= '0;
            r_gidx      <= w_win_idx;
            r_state     <= ST_GRANT;
          end else begin
            r_gnt  <= '0;
            r_busy <= 1'b0;
          end
        end
        ST_GRANT: begin
          r_plot    <= w_accept;
          r_timeout <= w_hit_max;
          if (w_accept) begin
            r_x         <= w_sel_x;
            r_y         <= w_sel_y;
            r_col       <= w_sel_col;
            r_burst_cnt <= w_cnt_next;
          end else begin
            r_burst_cnt <= r_burst_cnt;
          end
          if (w_release) begin
            r_gnt    <= '0;
            r_busy   <= 1'b0;
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_IDLE;
          end else begin
            r_state  <= ST_GRANT;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_gnt     <= '0;
          r_busy    <= 1'b0;
          r_plot    <= 1'b0;
          r_timeout <= 1'b0;
        end
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign x           = r_x;
  assign y           = r_y;
  assign colour      = r_col;
  assign plot        = r_plot;
  assign busy        = r_busy;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_sprite_plot_arbiter.sv
// Directed bench for sprite_plot_arbiter with a burst limit of 4: single burst, round-robin,
// isolation of non-granted engines, abort, forced release and asynchronous reset mid-burst.
module tb_sprite_plot_arbiter;
  localparam int N  = 5;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 3;
  localparam int MB = 4;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    px_valid;
  logic [N-1:0]    px_last;
  logic [N*XW-1:0] px_x;
  logic [N*YW-1:0] px_y;
  logic [N*CW-1:0] px_col;
  logic [N-1:0]    gnt;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [CW-1:0]   colour;
  logic            plot;
  logic            busy;
  logic            timeout_err;

  int n_vec = 0;
  int n_err = 0;

  sprite_plot_arbiter #(.N_REQ(N), .XW(XW), .YW(YW), .CW(CW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .px_valid(px_valid), .px_last(px_last),
    .px_x(px_x), .px_y(px_y), .px_col(px_col), .gnt(gnt), .x(x), .y(y),
    .colour(colour), .plot(plot), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input int i, input int xv, input int yv, input int cv);
    px_x[i*XW +: XW]   = XW'(xv);
    px_y[i*YW +: YW]   = YW'(yv);
    px_col[i*CW +: CW] = CW'(cv);
  endtask

  task automatic chk_px(input string tag, input int xv, input int yv, input int cv);
    chk({tag, "_plot"}, 32'(plot), 32'd1);
    chk({tag, "_x"}, 32'(x), 32'(xv));
    chk({tag, "_y"}, 32'(y), 32'(yv));
    chk({tag, "_col"}, 32'(colour), 32'(cv));
  endtask

  initial begin
    reset = 1'b0; req = '0; px_valid = '0; px_last = '0;
    px_x = '0; px_y = '0; px_col = '0;
    tick; tick;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_to", 32'(timeout_err), 32'd0);
    reset = 1'b1;
    tick;

    // Single requester 1, three pixels.
    req = 5'b00010;
    tick;
    chk("s_gnt", 32'(gnt), 32'b00010);
    chk("s_busy", 32'(busy), 32'd1);
    chk("s_plot0", 32'(plot), 32'd0);
    px_valid = 5'b00010; set_px(1, 10, 20, 3);
    tick; chk_px("s_p1", 10, 20, 3);
    set_px(1, 11, 20, 3);
    tick; chk_px("s_p2", 11, 20, 3);
    set_px(1, 12, 20, 3); px_last = 5'b00010;
    tick; chk_px("s_p3", 12, 20, 3);
    chk("s_rel_gnt", 32'(gnt), 32'd0);
    chk("s_rel_busy", 32'(busy), 32'd0);
    req = '0; px_valid = '0; px_last = '0;
    tick;
    chk("s_idle_plot", 32'(plot), 32'd0);

    // Round-robin from a fresh reset with everyone requesting.
    reset = 1'b0; tick; reset = 1'b1;
    for (int i = 0; i < N; i++) set_px(i, 100 + i, 1, i);
    req = 5'b11111; px_valid = 5'b11111; px_last = 5'b11111;
    for (int k = 0; k < 7; k++) begin
      tick;
      chk("rr_gnt", 32'(gnt), 32'(1 << (k % N)));
      chk("rr_plot_off", 32'(plot), 32'd0);
      tick;
      chk("rr_gap", 32'(gnt), 32'd0);
      chk("rr_x", 32'(x), 32'(100 + (k % N)));
      chk("rr_plot", 32'(plot), 32'd1);
    end
    req = '0; px_valid = '0; px_last = '0;
    tick;

    // Isolation: requester 4 waves pixel x=300 while requester 0 holds the grant.
    req = 5'b00001;
    tick;
    chk("iso_gnt", 32'(gnt), 32'b00001);
    req = 5'b10001; px_valid = 5'b10000; px_last = 5'b10000; set_px(4, 300, 9, 7);
    tick;
    chk("iso_plot1", 32'(plot), 32'd0);
    chk("iso_x1", 32'(x), 32'd101);
    tick;
    chk("iso_plot2", 32'(plot), 32'd0);
    chk("iso_x2", 32'(x), 32'd101);
    chk("iso_gnt2", 32'(gnt), 32'b00001);
    req = 5'b00001; px_valid = 5'b00001; px_last = 5'b00001; set_px(0, 5, 6, 1);
    tick; chk_px("iso_p0", 5, 6, 1);
    chk("iso_rel", 32'(gnt), 32'd0);
    req = '0; px_valid = '0; px_last = '0;
    tick;

    // Abort: requester 2 sends two pixels then drops req; rr_ptr must move to 3.
    req = 5'b00100;
    tick;
    chk("ab_gnt", 32'(gnt), 32'b00100);
    px_valid = 5'b00100; set_px(2, 30, 40, 5);
    tick; chk_px("ab_p1", 30, 40, 5);
    set_px(2, 31, 40, 5);
    tick; chk_px("ab_p2", 31, 40, 5);
    req = 5'b01001; px_valid = '0;
    tick;
    chk("ab_rel", 32'(gnt), 32'd0);
    chk("ab_plot", 32'(plot), 32'd0);
    chk("ab_to", 32'(timeout_err), 32'd0);
    tick;
    chk("ab_next3", 32'(gnt), 32'b01000);
    req = 5'b00001;
    tick;
    chk("ab3_rel", 32'(gnt), 32'd0);
    tick;
    chk("to_gnt", 32'(gnt), 32'b00001);

    // Forced release after 4 pixels without last.
    px_valid = 5'b00001; px_last = '0;
    for (int k = 0; k < MB; k++) begin
      set_px(0, 50 + k, 7, 2);
      tick;
      chk_px("to_p", 50 + k, 7, 2);
      chk("to_err", 32'(timeout_err), (k == MB - 1) ? 32'd1 : 32'd0);
      chk("to_gnt_k", 32'(gnt), (k == MB - 1) ? 32'd0 : 32'b00001);
    end
    set_px(0, 54, 7, 2);
    tick;
    chk("to_p5_plot", 32'(plot), 32'd0);
    chk("to_p5_x", 32'(x), 32'd53);
    chk("to_err_off", 32'(timeout_err), 32'd0);
    tick;
    chk("to_regnt", 32'(gnt), 32'b00001);
    tick;
    chk_px("ar_inflight", 54, 7, 2);

    // Asynchronous reset between edges mid-burst.
    #3 reset = 1'b0;
    #1;
    chk("ar_gnt", 32'(gnt), 32'd0);
    chk("ar_plot", 32'(plot), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_x", 32'(x), 32'd0);
    req = 5'b01010; px_valid = '0;
    tick;
    reset = 1'b1;
    tick;
    chk("ar_first", 32'(gnt), 32'b00010);
    chk("ar_busy2", 32'(busy), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sprite_plot_arbiter.md
Name: sprite_plot_arbiter

Overview:
- Shares the single VGA pixel-write port (x, y, colour, plot) among N sprite engines: player, aliens and bullet.
- Each engine raises a request, receives an exclusive grant, streams pixels, and releases on its last pixel.
- Arbitration is round-robin, so a stalled or slow engine cannot starve the others.
- A burst timeout guards against an engine that never signals its last pixel.

Parameters:
- N_REQ, 5, number of requesters (index 0 = player, 1..3 = aliens, 4 = bullet).
- XW, 9, pixel x width.
- YW, 8, pixel y width.
- CW, 3, colour width.
- MAX_BURST, 64, maximum valid pixels per grant before forced release (power of 2 not required; must be ≥1).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester bus request; held high until release.
- px_valid  in  N_REQ  requester presents a pixel this cycle.
- px_last  in  N_REQ  qualifies px_valid: final pixel of the burst.
- px_x  in  N_REQ*XW  packed x; requester i occupies bits [i*XW +: XW].
- px_y  in  N_REQ*YW  packed y; same packing.
- px_col  in  N_REQ*CW  packed colour; same packing.
- gnt  out  N_REQ  one-hot or zero grant, registered.
- x  out  XW  registered pixel x to VGA adapter.
- y  out  YW  registered pixel y.
- colour  out  CW  registered pixel colour.
- plot  out  1  write enable to VGA adapter, one pulse per accepted pixel.
- busy  out  1  high while a grant is held.
- timeout_err  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async, reset=0):
  - gnt=0, plot=0, x=0, y=0, colour=0, busy=0, timeout_err=0.
  - State=IDLE, rr_ptr=0, burst_cnt=0.
- State IDLE:
  - Scan req starting at index rr_ptr, wrapping modulo N_REQ; the first set bit g wins.
  - Next cycle: gnt=(1<<g), busy=1, burst_cnt=0, state=GRANT.
  - With no req set, remain in IDLE with gnt=0.
  - Grant appears exactly 1 cycle after req is sampled high in IDLE.
- State GRANT (winner g):
  - A pixel is accepted on a cycle where px_valid[g]=1 and req[g]=1.
  - Acceptance registers x/y/colour from slice g; plot=1 the following cycle (1-cycle latency).
  - plot=0 on any cycle without an acceptance in the previous cycle; x/y/colour hold their last value.
  - px_valid/px_last of non-granted requesters are ignored and never reach the outputs.
  - Each acceptance increments burst_cnt (width clog2(MAX_BURST+1)).
- Release conditions, evaluated in priority order within one cycle:
  - (a) Accepted pixel with px_last[g]=1: normal release; that pixel is still plotted.
  - (b) req[g]=0: abort; no pixel accepted that cycle.
  - (c) Acceptance that brings burst_cnt to MAX_BURST without px_last: forced release; that pixel is plotted; timeout_err=1 for one cycle, aligned with its plot.
- On any release:
  - Next cycle: gnt=0, busy=0, state=IDLE.
  - rr_ptr=(g+1) mod N_REQ.
  - IDLE arbitrates on the following cycle, so there is a mandatory 1-cycle gap between grants.
- Requester-side rules:
  - A requester that re-asserts req immediately after release is lowest priority relative to the others in the next arbitration.
  - Requests arriving mid-grant wait; they never pre-empt.
  - gnt is never multi-hot; gnt and busy change only on clk edges or async reset.
- Reset asserted mid-burst: all outputs clear immediately (asynchronously); any in-flight plot is dropped.

Test Plan:
- Single requester:
  - Stimulus: req[1]=1 alone with rr_ptr=0; 3 pixels (10,20,c=3), (11,20,3), (12,20,3 last).
  - Required: gnt=00010 one cycle after req; plot pulses carry exactly those 3 pixels, each 1 cycle after acceptance; gnt=0 the cycle after the last acceptance.
- Round-robin:
  - Stimulus: req=11111 held from reset; every requester sends 1-pixel bursts with last=1.
  - Required: grant order 0,1,2,3,4,0,1; one idle cycle between consecutive grants.
- Isolation:
  - Stimulus: gnt=00001; requester 4 drives px_valid=1 with x=300.
  - Required: x never shows 300 and no plot is caused by requester 4.
- Abort:
  - Stimulus: requester 2 is granted, sends 2 pixels, then drops req with no last.
  - Required: exactly 2 plot pulses; gnt=0 the next cycle; timeout_err stays 0; rr_ptr=3, so with req[0] and req[3] both pending, 3 wins.
- Timeout:
  - Stimulus: MAX_BURST=4; requester 0 streams continuous valid pixels with last=0.
  - Required: 4 plot pulses; timeout_err pulses with the 4th; gnt releases; the 5th pixel is not plotted.
- Async reset:
  - Stimulus: reset=0 asserted between clk edges mid-burst.
  - Required: gnt, plot, busy go to 0 before the next edge; after release, first grant goes to the lowest-index pending requester.
